// File: rtl/eth_cmd_pkg.sv
// rtl/eth_cmd_pkg.sv - shared constants, FSM encoding and helpers for eth_cmd_decoder
// Purpose: register map, frame byte offsets and decoder state encoding.
// Ports: none (package).
package eth_cmd_pkg;

  // Register map
  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_D_MAC      = 8'h01;
  localparam logic [7:0] ADDR_S_MAC      = 8'h02;
  localparam logic [7:0] ADDR_COUNTER_TH = 8'h03;
  localparam logic [7:0] ADDR_IDLE_TH    = 8'h04;

  // Frame byte offsets
  localparam logic [4:0] OFS_DMAC_LAST = 5'd5;
  localparam logic [4:0] OFS_ETYPE     = 5'd12;
  localparam logic [4:0] OFS_ADDR      = 5'd14;
  localparam logic [4:0] OFS_VAL_LAST  = 5'd20;
  localparam logic [4:0] IDX_MAX       = 5'd21;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_DRAIN,
    ST_DROP
  } state_t;

  // Byte i of a MAC address in wire order (byte 0 is the most significant).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [4:0] i);
    logic [47:0] sh;
    sh = mac << {i, 3'b000};
    return sh[47:40];
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - retriggerable fixed-width pulse generator
// Purpose: turns a one-cycle trigger into a LEN-cycle pulse starting the next cycle.
// Ports: clk, reset (async active-high), trigger (in), pulse (out).
module pulse_stretch #(
  parameter int LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic pulse
);

  logic [7:0] cnt;

  // A trigger during an active pulse reloads the count, restarting the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (trigger) begin
      cnt <= 8'(LEN);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign pulse = (cnt != 8'd0);

endmodule

// File: rtl/eth_cmd_decoder.sv
// rtl/eth_cmd_decoder.sv - Ethernet RX command frame decoder driving readout configuration
// Purpose: parses single-command frames from the MAC RX stream and updates config registers.
// Ports: clk, reset; rx_axis_tdata/tvalid/tlast (in), rx_axis_tready (out);
//        d_mac_add, s_mac_add, counter_th, idle_counter_number_th, tds_mode, enable,
//        soft_reset, frame_ok_cnt, frame_err_cnt (out).
module eth_cmd_decoder
  import eth_cmd_pkg::*;
#(
  parameter logic [15:0] CMD_ETHERTYPE  = 16'h88B5,
  parameter logic [47:0] DEF_D_MAC      = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] DEF_S_MAC      = 48'h0A35_0000_0001,
  parameter logic [11:0] DEF_COUNTER_TH = 12'd256,
  parameter logic [11:0] DEF_IDLE_TH    = 12'd1024,
  parameter int          RST_PULSE_LEN  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_axis_tdata,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  output logic        rx_axis_tready,
  output logic [47:0] d_mac_add,
  output logic [47:0] s_mac_add,
  output logic [11:0] counter_th,
  output logic [11:0] idle_counter_number_th,
  output logic        tds_mode,
  output logic [3:0]  enable,
  output logic        soft_reset,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt
);

  state_t      state, state_n;
  logic [4:0]  idx;
  logic        uc_ok, bc_ok;
  logic        uc_now, bc_now;
  logic [7:0]  addr_sh;
  logic [47:0] val_sh;
  logic [47:0] commit_val;
  logic        beat, commit, trunc, addr_valid, hdr_bad, trig;

  assign rx_axis_tready = ~reset;
  assign beat           = rx_axis_tvalid & rx_axis_tready;
  assign addr_valid     = (addr_sh <= ADDR_IDLE_TH);

  always_comb begin
    state_n    = state;
    commit     = 1'b0;
    trunc      = 1'b0;
    // Unicast and broadcast matches are tracked separately; the frame is
    // dropped only once neither can still match.
    uc_now     = uc_ok & (rx_axis_tdata == mac_byte(s_mac_add, idx));
    bc_now     = bc_ok & (rx_axis_tdata == 8'hFF);
    // When committing on byte 20 itself the last value byte is still on the bus.
    commit_val = (state == ST_PAYLOAD) ? {val_sh[39:0], rx_axis_tdata} : val_sh;
    hdr_bad    = ((idx <= OFS_DMAC_LAST) && !uc_now && !bc_now)
              || ((idx == OFS_ETYPE) && (rx_axis_tdata != CMD_ETHERTYPE[15:8]))
              || ((idx == OFS_ETYPE + 5'd1) && (rx_axis_tdata != CMD_ETHERTYPE[7:0]));
    if (beat) begin
      unique case (state)
        ST_HDR: begin
          if (rx_axis_tlast)                  state_n = ST_HDR;  // runt: silent discard
          else if (hdr_bad)                   state_n = ST_DROP;
          else if (idx == OFS_ETYPE + 5'd1)   state_n = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (idx == OFS_VAL_LAST) begin
            if (rx_axis_tlast) begin
              commit  = 1'b1;
              state_n = ST_HDR;
            end else begin
              state_n = ST_DRAIN;
            end
          end else if (rx_axis_tlast) begin
            trunc   = 1'b1;
            state_n = ST_HDR;
          end
        end
        ST_DRAIN: begin
          if (rx_axis_tlast) begin
            commit  = 1'b1;
            state_n = ST_HDR;
          end
        end
        ST_DROP: begin
          if (rx_axis_tlast) state_n = ST_HDR;
        end
        default: state_n = ST_HDR;
      endcase
    end
  end

  assign trig = commit & (addr_sh == ADDR_CTRL) & commit_val[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_HDR;
      idx   <= 5'd0;
      uc_ok <= 1'b1;
      bc_ok <= 1'b1;
    end else begin
      state <= state_n;
      if (beat) begin
        if (rx_axis_tlast) begin
          idx   <= 5'd0;
          uc_ok <= 1'b1;
          bc_ok <= 1'b1;
        end else begin
          if (idx != IDX_MAX) idx <= idx + 5'd1;
          if (state == ST_HDR && idx <= OFS_DMAC_LAST) begin
            uc_ok <= uc_now;
            bc_ok <= bc_now;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_sh <= 8'd0;
      val_sh  <= 48'd0;
    end else if (beat && state == ST_PAYLOAD) begin
      if (idx == OFS_ADDR) addr_sh <= rx_axis_tdata;
      else                 val_sh  <= {val_sh[39:0], rx_axis_tdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_mac_add              <= DEF_D_MAC;
      s_mac_add              <= DEF_S_MAC;
      counter_th             <= DEF_COUNTER_TH;
      idle_counter_number_th <= DEF_IDLE_TH;
      tds_mode               <= 1'b0;
      enable                 <= 4'hF;
      frame_ok_cnt           <= 16'd0;
      frame_err_cnt          <= 16'd0;
    end else begin
      if (commit && addr_valid) begin
        frame_ok_cnt <= frame_ok_cnt + 16'd1;
        unique case (addr_sh)
          ADDR_CTRL: begin
            tds_mode <= commit_val[1];
            enable   <= commit_val[5:2];
          end
          ADDR_D_MAC:      d_mac_add              <= commit_val;
          ADDR_S_MAC:      s_mac_add              <= commit_val;
          ADDR_COUNTER_TH: counter_th             <= commit_val[11:0];
          ADDR_IDLE_TH:    idle_counter_number_th <= commit_val[11:0];
          default: ;
        endcase
      end
      if (trunc || (commit && !addr_valid)) frame_err_cnt <= frame_err_cnt + 16'd1;
    end
  end

  pulse_stretch #(.LEN(RST_PULSE_LEN)) u_pulse (
    .clk     (clk),
    .reset   (reset),
    .trigger (trig),
    .pulse   (soft_reset)
  );

endmodule

// File: doc/eth_cmd_decoder.md
# eth_cmd_decoder

Receive-side command decoder for the Ethernet MAC's RX AXI-stream, replacing VIO-driven configuration of the TDS logger. Parses single-command Ethernet frames addressed to the board and updates the readout configuration: destination/source MAC, counter thresholds, TDS mode, channel enables and a soft-reset pulse. Runs entirely in the MAC clock domain, so it sits between `ethernet_mac_interface` RX and the configuration inputs of `readout_control` and `channel_data_4`. Crossing to clk160 is handled outside this block.

## Interface
Parameters:
- CMD_ETHERTYPE, 16'h88B5, EtherType that identifies command frames
- DEF_D_MAC, 48'hFFFF_FFFF_FFFF, reset value of d_mac_add
- DEF_S_MAC, 48'h0A35_0000_0001, reset value of s_mac_add, which is also the board's own address
- DEF_COUNTER_TH, 12'd256, reset value of counter_th
- DEF_IDLE_TH, 12'd1024, reset value of idle_counter_number_th
- RST_PULSE_LEN, 16, soft_reset width in clk cycles (1..255)

Ports:
- Clock and reset: one clock `clk`; `reset` is asynchronous, active-high.
- clk  in  1  MAC clock (gtx_clk_bufg_out)
- reset  in  1  async active-high reset
- rx_axis_tdata  in  8  frame byte
- rx_axis_tvalid  in  1  byte valid
- rx_axis_tlast  in  1  last byte of frame
- rx_axis_tready  out  1  0 while reset, else constant 1
- d_mac_add  out  48  destination MAC for readout frames
- s_mac_add  out  48  source MAC / local address
- counter_th  out  12  readout counter threshold
- idle_counter_number_th  out  12  idle threshold
- tds_mode  out  1  0 = pad, 1 = strip; reset 0
- enable  out  4  per-channel enable; reset 4'hF
- soft_reset  out  1  stretched reset pulse; reset 0
- frame_ok_cnt  out  16  committed commands, wraps; reset 0
- frame_err_cnt  out  16  malformed commands, wraps; reset 0

## Operation
Frame byte index `idx` counts accepted beats (tvalid & tready). It saturates at 21 and clears after the tlast beat.

Byte layout:
- Bytes 0–5: destination MAC. Must equal s_mac_add or be all-ones (broadcast).
- Bytes 6–11: sender MAC (ignored).
- Bytes 12–13: EtherType, big-endian.
- Byte 14: register address.
- Bytes 15–20: 48-bit value, big-endian.
- Bytes 21 and beyond: padding, ignored.

FSM states:
- HDR: bytes 0–13. Compare destination MAC and EtherType on the fly.
  - Any mismatch goes to DROP.
  - Byte 13 matching goes to PAYLOAD.
  - tlast in HDR (runt frame): silent discard, no counter change.
- PAYLOAD: bytes 14–20 are captured into addr/value shadow registers.
  - Byte 20 goes to DRAIN.
  - tlast before byte 20: frame_err_cnt++, return to HDR.
- DRAIN: wait for tlast.
- DROP: wait for tlast, no counter change.
- Commit happens on the tlast beat while in DRAIN, or on byte 20 itself if it carries tlast. Return to HDR.

Register map, applied at commit:
- 0x00 control: value[0]=1 triggers soft_reset; value[1] goes to tds_mode; value[5:2] go to enable.
- 0x01: d_mac_add = value.
- 0x02: s_mac_add = value. The new address is used for matching from the next frame onward.
- 0x03: counter_th = value[11:0].
- 0x04: idle_counter_number_th = value[11:0].
- Any other address: frame_err_cnt++, no register change.
- Each valid commit: frame_ok_cnt++.

soft_reset:
- Asserts for exactly RST_PULSE_LEN cycles starting the cycle after commit.
- A new trigger during a pulse restarts the count.
- soft_reset does not reset this block's own registers.

## Timing
- Register outputs and counters update on the clock edge after the committing tlast beat, i.e. 1-cycle latency.
- Back-to-back frames: the first byte of the next frame may arrive on the cycle after tlast and is parsed normally.
- tvalid low beats are ignored with no timeout; state is held.
- Async reset mid-frame: FSM returns to HDR, the partial frame is discarded, and all outputs take their defaults immediately.
- A frame whose tlast arrives while the soft_reset pulse is active is processed normally.

## Structure
- Package `eth_cmd_pkg` holds:
  - Register address constants (ADDR_CTRL..ADDR_IDLE_TH)
  - Byte-offset constants (OFS_ETYPE=12, OFS_ADDR=14, OFS_VAL_LAST=20)
  - FSM state encoding
- Sub-module `pulse_stretch` (trigger in, RST_PULSE_LEN counter) generates soft_reset.

## Test plan
- Unicast frame to DEF_S_MAC, EtherType 88B5, addr 0x03, value 0x000000000ABC, padded to 60 bytes → counter_th=12'hABC one cycle after tlast; frame_ok_cnt=1.
- Broadcast frame, addr 0x00, value 0x27 → tds_mode=1, enable=4'h9, soft_reset high for 16 cycles.
- Frame with EtherType 0x0800, or with destination MAC 02:00:00:00:00:01 → no change; both counters unchanged.
- Command frame with tlast at byte 17 → frame_err_cnt=1; registers unchanged.
- Write addr 0x02 = 0x112233445566, then a frame to DEF_S_MAC → second frame dropped; a frame to 11:22:33:44:55:66 is accepted.
- Assert reset at byte 16 of a valid frame, release, then send a new valid frame → defaults restored; only the new frame commits.
